ledr_pattern_sequencer: RTL and testbench
=========================================

// Module: ledr_pattern_sequencer
// PURPOSE
//  Avalon-MM slave that drives the LED bank with hardware-sequenced patterns, so the Nios II does not need to update them.
//  Supported patterns: static, blink, rotate and bounce. Step rate comes from a programmable prescaler.
//  Sits between the system interconnect and the board LEDs, in place of a plain output PIO.
//  Register read is zero-wait-state; the same bus timing as the PIO it replaces.
// PARAMETERS
//  LED_W       10           number of LEDs driven
//  PERIOD_W    24           width of step-period register / prescaler counter
//  PERIOD_RST  24'd5000000  PERIOD reset value (100 ms step at 50 MHz)
// PORTS
//  clk         in   1         system clock
//  reset_n     in   1         asynchronous, active-low reset
//  address     in   2         register select
//  chipselect  in   1         slave select
//  write_n     in   1         active-low write strobe
//  writedata   in   32        write data
//  readdata    out  32        read data, combinational from address (0 wait states)
//  out_port    out  LED_W     LED drive
// BEHAVIOUR
//  Reset: all state is asynchronously cleared on reset_n=0.
//   - DATA=0, CTRL=0, PERIOD=PERIOD_RST, step_cnt=0, prescaler=0, FSM=IDLE.
//   - Outputs out_port=0 and readdata=0 (address 0 -> DATA=0).
//  Register map. A write is chipselect & ~write_n. Unused readdata bits read 0.
//   - addr0 DATA   RW  [LED_W-1:0] base pattern.
//   - addr1 CTRL   RW  [0] enable; [2:1] mode: 0 static, 1 blink, 2 rotate, 3 bounce.
//   - addr2 PERIOD RW  [PERIOD_W-1:0] clocks per step. A value of 0 behaves as 1.
//   - addr3 STATUS RO  [0] running; [1] dir (1=reverse); [31:16] step_cnt. Any write clears step_cnt only.
//  FSM states: IDLE, RUN_FWD, RUN_REV.
//   - IDLE: out_port=DATA, prescaler held at 0. A CTRL write with enable=1 loads work=DATA, phase=0, prescaler=0, step_cnt=0 and moves to RUN_FWD.
//   - RUN_*: a CTRL write with enable=0 moves to IDLE. A CTRL write with enable=1 restarts (same load as from IDLE).
//   - RUN_*: a DATA write reloads work=new DATA, phase=0, prescaler=0 and state=RUN_FWD; step_cnt is kept.
//   - RUN_*: a PERIOD write clears the prescaler only.
//  Prescaler: counts 0..max(PERIOD,1)-1.
//   - The tick is the cycle in which the count equals its max. That edge wraps the counter to 0 and performs one step.
//   - With PERIOD=N, out_port changes every N clocks. The first change comes N clocks after the enabling write.
//   - A register write in the same cycle as a tick takes priority; the step is discarded.
//  Steps by mode (performed at the tick edge):
//   - static: no change; out_port=DATA.
//   - blink: phase toggles; out_port = phase ? 0 : work.
//   - rotate: work = {work[LED_W-2:0], work[LED_W-1]}, i.e. MSB wraps to bit0.
//   - bounce, RUN_FWD: if work[LED_W-1], go to RUN_REV and work>>=1; else work<<=1.
//   - bounce, RUN_REV: if work[0], go to RUN_FWD and work<<=1; else work>>=1.
//   - bounce edge cases: work=0 stays 0; all-ones is still well defined by the rules above.
//  Every step increments step_cnt, including static mode. step_cnt wraps 0xFFFF->0.
//  When running, out_port=work (blink: gated by phase). Output is registered, with no glitch on mode change.
//  Reset asserted mid-run returns to the full reset state at once, with no completion of the pending step.
// TESTING
//  1 Reset -> out_port=0; read addr0=0, addr1=0, addr2=PERIOD_RST, addr3=0.
//  2 DATA=0x001, PERIOD=4, CTRL=0x5 (rotate) -> out 0x001,0x002,...,0x200,0x001, stepping every 4 clk; STATUS[31:16]=10 after 40 clk.
//  3 DATA=0x2AA, PERIOD=0, CTRL=0x3 (blink) -> out alternates 0x2AA/0x000 every clk.
//  4 DATA=0x100, PERIOD=1, CTRL=0x7 (bounce) -> 0x100,0x200,0x100,0x080; STATUS[1] 0->1 at the 0x200->0x100 step.
//  5 Rotate running, PERIOD=3, DATA write 0x00F on a tick cycle -> next out 0x00F, no shift; 0x01E after 3 more clk.
//  6 Bounce running, reset_n low 1 clk mid-period -> out_port=0, STATUS=0, PERIOD=PERIOD_RST; stays IDLE after release.

Source files
------------

// File: rtl/ledr_pattern_sequencer.sv
// Avalon-MM LED sequencer: drives the LED bank with static, blink, rotate or
// bounce patterns stepped by a programmable prescaler, replacing a plain PIO.
module ledr_pattern_sequencer #(
  parameter int unsigned           LED_W      = 10,
  parameter int unsigned           PERIOD_W   = 24,
  parameter logic [PERIOD_W-1:0]   PERIOD_RST = PERIOD_W'(5000000)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] out_port
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_FWD = 2'd1,
    ST_RUN_REV = 2'd2
  } state_e;

  state_e              state_q,  state_d;
  logic [LED_W-1:0]    data_q,   data_d;
  logic                en_q,     en_d;
  logic [1:0]          mode_q,   mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] presc_q,  presc_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [LED_W-1:0]    work_q,   work_d;
  logic                phase_q,  phase_d;
  logic [LED_W-1:0]    out_q,    out_d;

  logic                wr_c;
  logic                running_c;
  logic                tick_c;
  logic [PERIOD_W-1:0] presc_max_c;
  logic                unused_wdata;

  assign wr_c         = chipselect & ~write_n;
  assign running_c    = (state_q != ST_IDLE);
  assign presc_max_c  = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign tick_c       = running_c && (presc_q == presc_max_c);
  assign unused_wdata = ^writedata[31:PERIOD_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      en_q     <= 1'b0;
      mode_q   <= MODE_STATIC;
      period_q <= PERIOD_RST;
      presc_q  <= '0;
      cnt_q    <= '0;
      work_q   <= '0;
      phase_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  // Next state: prescaler/step first, then register writes override the step.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    en_d     = en_q;
    mode_d   = mode_q;
    period_d = period_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    phase_d  = phase_q;
    out_d    = out_q;

    if (running_c) begin
      presc_d = tick_c ? '0 : presc_q + PERIOD_W'(1);
    end

    if (tick_c && !wr_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (mode_q)
        MODE_BLINK:  phase_d = ~phase_q;
        MODE_ROTATE: work_d  = {work_q[LED_W-2:0], work_q[LED_W-1]};
        MODE_BOUNCE: begin
          if (state_q == ST_RUN_FWD) begin
            if (work_q[LED_W-1]) begin
              state_d = ST_RUN_REV;
              work_d  = work_q >> 1;
            end else begin
              work_d  = work_q << 1;
            end
          end else begin
            if (work_q[0]) begin
              state_d = ST_RUN_FWD;
              work_d  = work_q << 1;
            end else begin
              work_d  = work_q >> 1;
            end
          end
        end
        default: ;
      endcase
    end

    if (wr_c) begin
      case (address)
        ADDR_DATA: begin
          data_d = writedata[LED_W-1:0];
          if (running_c) begin
            state_d = ST_RUN_FWD;
            work_d  = writedata[LED_W-1:0];
            phase_d = 1'b0;
            presc_d = '0;
          end
        end
        ADDR_CTRL: begin
          en_d   = writedata[0];
          mode_d = writedata[2:1];
          presc_d = '0;
          if (writedata[0]) begin
            state_d = ST_RUN_FWD;
            work_d  = data_q;
            phase_d = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ADDR_PERIOD: begin
          period_d = writedata[PERIOD_W-1:0];
          presc_d  = '0;
        end
        ADDR_STATUS: cnt_d = '0;
        default: ;
      endcase
    end

    // Output derived from next-state values so it never lags a register write.
    if (state_d == ST_IDLE || mode_d == MODE_STATIC) begin
      out_d = data_d;
    end else if (mode_d == MODE_BLINK) begin
      out_d = phase_d ? '0 : work_d;
    end else begin
      out_d = work_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_CTRL:   readdata = {29'd0, mode_q, en_q};
      ADDR_PERIOD: readdata = 32'(period_q);
      ADDR_STATUS: readdata = {cnt_q, 14'd0, (state_q == ST_RUN_REV), running_c};
      default:     readdata = '0;
    endcase
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_ledr_pattern_sequencer.sv
// Randomized self-checking bench for ledr_pattern_sequencer against a
// behavioural model of the LED pattern rules.
module tb_ledr_pattern_sequencer;

  localparam int unsigned LED_W      = 10;
  localparam int unsigned PERIOD_W   = 24;
  localparam int          PERIOD_RST = 5000000;
  localparam int          MASK       = (1 << LED_W) - 1;
  localparam int          MSB_VAL    = 1 << (LED_W - 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [LED_W-1:0] out_port;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_data, m_en, m_mode, m_period, m_steps, m_cnt, m_pat, m_phase, m_rev, m_run;

  ledr_pattern_sequencer #(
    .LED_W      (LED_W),
    .PERIOD_W   (PERIOD_W),
    .PERIOD_RST (PERIOD_W'(PERIOD_RST))
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_data = 0; m_en = 0; m_mode = 0; m_period = PERIOD_RST;
    m_steps = 0; m_cnt = 0; m_pat = 0; m_phase = 0; m_rev = 0; m_run = 0;
  endfunction

  function automatic int m_out();
    if (!m_run || m_mode == 0) return m_data;
    if (m_mode == 1) return m_phase ? 0 : m_pat;
    return m_pat;
  endfunction

  function automatic int m_read(input int a);
    case (a)
      0: return m_data;
      1: return (m_mode << 1) | m_en;
      2: return m_period;
      default: return (m_steps << 16) | (m_rev << 1) | m_run;
    endcase
  endfunction

  function automatic void m_step();
    m_steps = (m_steps + 1) % 65536;
    case (m_mode)
      1: m_phase = 1 - m_phase;
      2: m_pat = ((m_pat * 2) | (m_pat / MSB_VAL)) & MASK;
      3: begin
        if (!m_rev) begin
          if (m_pat >= MSB_VAL) begin m_rev = 1; m_pat = m_pat / 2; end
          else m_pat = (m_pat * 2) & MASK;
        end else begin
          if (m_pat % 2 == 1) begin m_rev = 0; m_pat = (m_pat * 2) & MASK; end
          else m_pat = m_pat / 2;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void m_restart();
    m_pat = m_data; m_phase = 0; m_cnt = 0; m_rev = 0;
  endfunction

  // One clock edge of the model, given the bus inputs present at that edge.
  function automatic void m_edge(input bit wr, input int a, input int wd);
    int  pmax;
    bit  tick;
    pmax = (m_period == 0) ? 0 : m_period - 1;
    tick = m_run && (m_cnt == pmax);
    if (m_run) m_cnt = tick ? 0 : m_cnt + 1;
    if (wr) begin
      case (a)
        0: begin m_data = wd & MASK; if (m_run) m_restart(); end
        1: begin
          m_en = wd & 1; m_mode = (wd >> 1) & 3;
          if (m_en) begin m_run = 1; m_restart(); m_steps = 0; end
          else begin m_run = 0; m_cnt = 0; m_rev = 0; m_phase = 0; end
        end
        2: begin m_period = wd & 32'h00FF_FFFF; m_cnt = 0; end
        default: m_steps = 0;
      endcase
    end else if (tick) begin
      m_step();
    end
  endfunction

  task automatic cyc(input bit cs, input bit wn, input int a, input int wd);
    chipselect = cs; write_n = wn; address = 2'(a); writedata = wd;
    @(posedge clk);
    m_edge(cs && !wn, a, wd);
    #1;
    check_eq("out_port", 32'(out_port), m_out());
    check_eq("readdata", readdata, m_read(a));
  endtask

  task automatic wr_reg(input int a, input int wd);
    cyc(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input int n, input int a);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, a, $urandom);
  endtask

  // Asynchronous reset pulse taken between clock edges.
  task automatic pulse_reset();
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b0;
    m_reset();
    #1;
    check_eq("rst_out", 32'(out_port), 0);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check_eq("rst_read", readdata, m_read(a));
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_eq("reset_out", 32'(out_port), 0);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check_eq("reset_reg", readdata, (a == 2) ? PERIOD_RST : 0);
    end
    reset_n = 1'b1;

    // Rotate, 4 clocks per step
    wr_reg(0, 32'h001); wr_reg(2, 4); wr_reg(1, 32'h5);
    check_eq("t2_first", 32'(out_port), 32'h001);
    idle(40, 3);
    check_eq("t2_steps", 32'(readdata[31:16]), 10);
    check_eq("t2_wrap", 32'(out_port), 32'h001);

    // Blink with PERIOD=0 toggles every clock
    wr_reg(0, 32'h2AA); wr_reg(2, 0); wr_reg(1, 32'h3);
    check_eq("t3_on", 32'(out_port), 32'h2AA);
    idle(1, 0);
    check_eq("t3_off", 32'(out_port), 32'h000);
    idle(1, 0);
    check_eq("t3_on2", 32'(out_port), 32'h2AA);
    idle(6, 1);

    // Bounce at the top edge
    wr_reg(0, 32'h100); wr_reg(2, 1); wr_reg(1, 32'h7);
    check_eq("t4_start", 32'(out_port), 32'h100);
    idle(1, 3);
    check_eq("t4_s1", 32'(out_port), 32'h200);
    check_eq("t4_dir1", 32'(readdata[1]), 0);
    idle(1, 3);
    check_eq("t4_s2", 32'(out_port), 32'h100);
    check_eq("t4_dir2", 32'(readdata[1]), 1);
    idle(1, 3);
    check_eq("t4_s3", 32'(out_port), 32'h080);

    // DATA write on a tick cycle wins over the step
    wr_reg(0, 32'h001); wr_reg(2, 3); wr_reg(1, 32'h5);
    idle(2, 3);
    check_eq("t5_pre", 32'(out_port), 32'h001);
    wr_reg(0, 32'h00F);
    check_eq("t5_load", 32'(out_port), 32'h00F);
    idle(2, 3);
    check_eq("t5_hold", 32'(out_port), 32'h00F);
    idle(1, 3);
    check_eq("t5_shift", 32'(out_port), 32'h01E);

    // Reset in the middle of a bounce period
    wr_reg(0, 32'h001); wr_reg(2, 8); wr_reg(1, 32'h7);
    idle(11, 3);
    pulse_reset();
    idle(5, 3);
    check_eq("t6_idle_out", 32'(out_port), 0);
    check_eq("t6_status", readdata, 0);
    idle(1, 2);
    check_eq("t6_period", readdata, PERIOD_RST);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (i % 700 == 350) begin
        pulse_reset();
      end else if (r < 10) begin
        int a, wd;
        a  = $urandom_range(0, 3);
        wd = $urandom;
        if (a == 2) wd = $urandom_range(0, 5) | (($urandom & 32'hFF) << 24);
        if (a == 1 && $urandom_range(0, 3) != 0) wd = wd | 1;
        wr_reg(a, wd);
      end else begin
        cyc($urandom_range(0, 1), 1'b1, $urandom_range(0, 3), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
